// File: rtl/cfsr_pkg.sv
// Shared definitions for the complemented-feedback (Johnson) shift register:
// default width, reset value and the Johnson-form legality check.
package cfsr_pkg;

    localparam int CFSR_DEFAULT_WIDTH = 4;

    // Widest register the legality helper can examine.
    localparam int CFSR_MAX_WIDTH = 32;

    localparam logic [CFSR_MAX_WIDTH-1:0] CFSR_RESET_VALUE = '0;

    // A Johnson state has at most one boundary between adjacent unequal bits:
    // 1^k 0^(W-k) or 0^k 1^(W-k). Bits at and above 'width' are ignored.
    function automatic logic cfsr_is_legal(input logic [CFSR_MAX_WIDTH-1:0] state,
                                           input int width);
        int edges;
        edges = 0;
        for (int i = 0; i < CFSR_MAX_WIDTH - 1; i++) begin
            if ((i < width - 1) && (state[i] != state[i+1])) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/cfsr_state_check.sv
// Combinational Johnson-form legality check of a WIDTH-bit counter state.
// Only instantiated when CFSR_SELF_CORRECT_EN is defined.
module cfsr_state_check
    import cfsr_pkg::*;
#(
    parameter int WIDTH = CFSR_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] state,
    output logic             legal
);

    logic [CFSR_MAX_WIDTH-1:0] state_wide;

    // Zero-extend so the shared helper can be reused for any WIDTH up to its maximum.
    assign state_wide = CFSR_MAX_WIDTH'(state);
    assign legal      = cfsr_is_legal(state_wide, WIDTH);

endmodule

// File: rtl/cfsr_4bit.sv
// Complemented-feedback (Johnson / twisted-ring) counter, period 2*WIDTH.
// Shifts right each clock, feeding ~LSB into the MSB; the register is the output.
// Optional macro CFSR_SELF_CORRECT_EN: an illegal state is sent to all zeros
// on the next edge instead of circulating in a parasitic cycle.
module cfsr_4bit
    import cfsr_pkg::*;
#(
    parameter int WIDTH = CFSR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] CFSR
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_state;

    assign shifted = {~state[0], state[WIDTH-1:1]};

`ifdef CFSR_SELF_CORRECT_EN
    logic legal;

    cfsr_state_check #(
        .WIDTH(WIDTH)
    ) u_state_check (
        .state(state),
        .legal(legal)
    );

    // Illegal states recover to zero in one step; legal ones shift normally.
    assign next_state = legal ? shifted : '0;
`else
    assign next_state = shifted;
`endif

    // State register with synchronous reset taking priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CFSR_RESET_VALUE[WIDTH-1:0];
        end else begin
            state <= next_state;
        end
    end

    assign CFSR = state;

endmodule

// File: tb/tb_cfsr_4bit.sv
// Directed self-checking bench for cfsr_4bit (WIDTH=4 and WIDTH=6 instances).
module tb_cfsr_4bit;
    import cfsr_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] cfsr4;
    logic [5:0] cfsr6;

    int n_cmp;
    int n_err;

    logic [3:0] exp4 [8];
    logic [5:0] exp6 [12];

    cfsr_4bit #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .CFSR(cfsr4)
    );

    cfsr_4bit #(.WIDTH(6)) dut6 (
        .clk (clk),
        .rst (rst),
        .CFSR(cfsr6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (cfsr4 !== 4'b0000) begin
            n_err++;
            $display("FAIL reset4: got %b want 0000", cfsr4);
        end
        n_cmp++;
        if (cfsr6 !== 6'b000000) begin
            n_err++;
            $display("FAIL reset6: got %b want 000000", cfsr6);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (cfsr4 !== exp4[i]) begin
                n_err++;
                $display("FAIL first_seq[%0d]: got %b want %b", i, cfsr4, exp4[i]);
            end
        end
    endtask

    task automatic test_free_run();
        logic [3:0] prev;
        prev = cfsr4;
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (cfsr4 !== exp4[i % 8]) begin
                n_err++;
                $display("FAIL free_run[%0d]: got %b want %b", i, cfsr4, exp4[i % 8]);
            end
            n_cmp++;
            if ($countones(cfsr4 ^ prev) != 1) begin
                n_err++;
                $display("FAIL one_bit[%0d]: got %b after %b want one bit changed", i, cfsr4, prev);
            end
            prev = cfsr4;
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (cfsr4 !== 4'b1110) begin
            n_err++;
            $display("FAIL mid_setup: got %b want 1110", cfsr4);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (cfsr4 !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset: got %b want 0000", cfsr4);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (cfsr4 !== 4'b1000) begin
            n_err++;
            $display("FAIL mid_resume: got %b want 1000", cfsr4);
        end
    endtask

    task automatic test_illegal();
        logic [3:0] want [8];
`ifdef CFSR_SELF_CORRECT_EN
        want = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
`else
        want = '{4'b1010, 4'b1101, 4'b0110, 4'b1011, 4'b0101, 4'b0010, 4'b1001, 4'b0100};
`endif
        @(negedge clk);
        force dut.state = 4'b0100;
        #1;
        release dut.state;
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (cfsr4 !== want[i]) begin
                n_err++;
                $display("FAIL illegal[%0d]: got %b want %b", i, cfsr4, want[i]);
            end
        end
        // A legal state must shift normally in either configuration.
        force dut.state = 4'b0011;
        #1;
        release dut.state;
        step();
        n_cmp++;
        if (cfsr4 !== 4'b0001) begin
            n_err++;
            $display("FAIL legal_force: got %b want 0001", cfsr4);
        end
    endtask

    task automatic test_legal_fn();
        logic [CFSR_MAX_WIDTH-1:0] s [6];
        logic                      want [6];
        s    = '{32'h4, 32'h3, 32'hC, 32'hA, 32'h0, 32'hF};
        want = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (cfsr_is_legal(s[i], 4) !== want[i]) begin
                n_err++;
                $display("FAIL legal_fn[%0d]: state %h got %b want %b",
                         i, s[i][3:0], cfsr_is_legal(s[i], 4), want[i]);
            end
        end
    endtask

    task automatic test_width6();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            n_cmp++;
            if (cfsr6 !== exp6[i % 12]) begin
                n_err++;
                $display("FAIL width6[%0d]: got %b want %b", i, cfsr6, exp6[i % 12]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        exp4  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                  4'b0111, 4'b0011, 4'b0001, 4'b0000};
        exp6  = '{6'b100000, 6'b110000, 6'b111000, 6'b111100, 6'b111110, 6'b111111,
                  6'b011111, 6'b001111, 6'b000111, 6'b000011, 6'b000001, 6'b000000};
        test_reset();
        test_free_run();
        test_mid_reset();
        test_illegal();
        test_legal_fn();
        test_width6();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
